conv_kernel_loader: RTL

Parametrised convolution-kernel fetch engine for the CNN datapath. It reads K×K signed weights per kernel from a synchronous weight RAM, assembles them into one flat parallel word, and presents each kernel to the convolution array over a valid/ready handshake. It generalises the fixed 5×5, 1-bit kernel reader with configurable kernel size, weight width and kernel count, plus single-kernel and sweep-all modes. It sits between the weight BRAM and the conv engine.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/kernel_tap_regs.sv | 43 ++++
 rtl/conv_kernel_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: default kernel geometry,
// the kernel loader state encoding and small sizing helpers.
package cnn_pkg;

    localparam int CNN_K        = 5;
    localparam int CNN_DATA_W   = 8;
    localparam int CNN_NUM_KERN = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PRESENT = 2'd3
    } loader_state_e;

    // Number of taps in a square kernel of side k.
    function automatic int taps_of(input int k);
        return k * k;
    endfunction

    // Bits needed to index n items, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kernel_tap_regs.sv
// Register bank holding one kernel's taps; a single tap is written per
// cycle and the whole bank is exposed as one flat parallel word.
module kernel_tap_regs
    import cnn_pkg::*;
#(
    parameter int TAPS   = 25,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [TAPS*DATA_W-1:0]   taps_flat
);

    logic [TAPS-1:0][DATA_W-1:0] regs_q;
    logic [TAPS-1:0][DATA_W-1:0] regs_d;

    // Clear wins over a write; out-of-range indices are dropped.
    always_comb begin
        regs_d = regs_q;
        if (clr) begin
            regs_d = '0;
        end else if (wr_en && (int'(wr_idx) < TAPS)) begin
            regs_d[wr_idx] = wr_data;
        end
    end

    // Tap storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign taps_flat = regs_q;

endmodule

// File: rtl/conv_kernel_loader.sv
// Fetches K*K signed weights per kernel from a synchronous weight RAM,
// assembles them into a flat word and hands each kernel to the conv
// array over valid/ready. Supports single-kernel and sweep-to-end modes.
module conv_kernel_loader
    import cnn_pkg::*;
#(
    parameter int K        = CNN_K,
    parameter int DATA_W   = CNN_DATA_W,
    parameter int NUM_KERN = CNN_NUM_KERN,
    parameter int ADDR_W   = width_of(NUM_KERN * K * K),
    parameter int IDX_W    = width_of(NUM_KERN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        mode,
    input  logic [IDX_W-1:0]            kern_sel,
    output logic                        ram_rd_en,
    output logic [ADDR_W-1:0]           ram_addr,
    input  logic [DATA_W-1:0]           ram_rdata,
    output logic [K*K*DATA_W-1:0]       kernel_data,
    output logic [IDX_W-1:0]            kernel_idx,
    output logic                        kernel_valid,
    input  logic                        kernel_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int TAPS  = taps_of(K);
    localparam int TAP_W = width_of(TAPS + 1);

    loader_state_e      state_q, state_d;
    logic               mode_q, mode_d;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               ram_rd_en_q, ram_rd_en_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [TAP_W-1:0]   rd_tap_q, rd_tap_d;
    logic               cap_en_q, cap_en_d;
    logic [TAP_W-1:0]   cap_idx_q, cap_idx_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               taps_clr;
    logic               sel_legal;
    logic               more_kernels;

    assign sel_legal    = (int'(kern_sel) < NUM_KERN);
    assign more_kernels = mode_q && (int'(cur_idx_q) < (NUM_KERN - 1));

    // Next-state, read issue and capture pipeline. Reads are registered, so
    // the RAM word for a read arrives two edges after it is issued; the
    // capture stage tracks that with cap_en/cap_idx, and FETCH spends one
    // extra cycle after the last issue so DRAIN can absorb the final word.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cur_idx_d   = cur_idx_q;
        tap_d       = tap_q;
        ram_rd_en_d = 1'b0;
        ram_addr_d  = ram_addr_q;
        rd_tap_d    = rd_tap_q;
        cap_en_d    = ram_rd_en_q;
        cap_idx_d   = rd_tap_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        taps_clr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (sel_legal) begin
                        mode_d    = mode;
                        cur_idx_d = kern_sel;
                        tap_d     = '0;
                        taps_clr  = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (int'(tap_q) < TAPS) begin
                    ram_rd_en_d = 1'b1;
                    ram_addr_d  = ADDR_W'(cur_idx_q) * ADDR_W'(TAPS) + ADDR_W'(tap_q);
                    rd_tap_d    = tap_q;
                    tap_d       = tap_q + 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (kernel_ready) begin
                    if (more_kernels) begin
                        cur_idx_d = cur_idx_q + 1'b1;
                        tap_d     = '0;
                        state_d   = ST_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            cur_idx_q   <= '0;
            tap_q       <= '0;
            ram_rd_en_q <= 1'b0;
            ram_addr_q  <= '0;
            rd_tap_q    <= '0;
            cap_en_q    <= 1'b0;
            cap_idx_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cur_idx_q   <= cur_idx_d;
            tap_q       <= tap_d;
            ram_rd_en_q <= ram_rd_en_d;
            ram_addr_q  <= ram_addr_d;
            rd_tap_q    <= rd_tap_d;
            cap_en_q    <= cap_en_d;
            cap_idx_q   <= cap_idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    kernel_tap_regs #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .IDX_W  (TAP_W)
    ) u_taps (
        .clk       (clk),
        .rst       (rst),
        .clr       (taps_clr),
        .wr_en     (cap_en_q),
        .wr_idx    (cap_idx_q),
        .wr_data   (ram_rdata),
        .taps_flat (kernel_data)
    );

    assign ram_rd_en    = ram_rd_en_q;
    assign ram_addr     = ram_addr_q;
    assign kernel_idx   = cur_idx_q;
    assign kernel_valid = (state_q == ST_PRESENT);
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err          = err_q;

endmodule
